// File: rtl/key_debounce.sv
// key_debounce: synchronises a raw push-button pin and lets key_level follow a new
// level only after it has been seen unchanged for DEBOUNCE_CYCLES+1 consecutive clocks.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_in,
    output logic key_level,
    output logic bouncing
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic             RELEASED_LVL = KEY_ACTIVE_LOW;

    logic             sync1_r;
    logic             sync2_r;
    logic             pressed_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             key_level_r;
    logic             bouncing_r;
    logic             level_nxt_s;
    logic             bouncing_nxt_s;

    // Two-flop synchroniser; the FSM only ever looks at sync2_r.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= RELEASED_LVL;
            sync2_r <= RELEASED_LVL;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = sync2_r ^ KEY_ACTIVE_LOW;

    // Next-state and qualification counter; any opposite sample while arming restarts from idle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (pressed_s) begin
                    state_nxt_s = ARM_PRESS;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM_PRESS: begin
                if (!pressed_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_nxt_s = ARM_RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            ARM_RELEASE: begin
                if (pressed_s) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode of the upcoming state, so the output flops mirror the state register.
    always_comb begin
        level_nxt_s    = (state_nxt_s == PRESSED)   || (state_nxt_s == ARM_RELEASE);
        bouncing_nxt_s = (state_nxt_s == ARM_PRESS) || (state_nxt_s == ARM_RELEASE);
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            key_level_r <= 1'b0;
            bouncing_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            key_level_r <= level_nxt_s;
            bouncing_r  <= bouncing_nxt_s;
        end
    end

    assign key_level = key_level_r;
    assign bouncing  = bouncing_r;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high instance driven by directed
// scenarios and random hold lengths, compared every cycle against a sample-history model.
module tb_key_debounce;

    localparam int D  = 4;
    localparam int HW = D + 1;
    localparam logic [1:0] AL = 2'b01;

    logic       clock;
    logic       resetn;
    logic [1:0] key_r;
    logic       key_level_lo;
    logic       bouncing_lo;
    logic       key_level_hi;
    logic       bouncing_hi;

    int checks_cnt = 0;
    int errors_cnt = 0;

    key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .KEY_ACTIVE_LOW(1'b1)) dut_lo (
        .clock     (clock),
        .resetn    (resetn),
        .key_in    (key_r[0]),
        .key_level (key_level_lo),
        .bouncing  (bouncing_lo)
    );

    key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .KEY_ACTIVE_LOW(1'b0)) dut_hi (
        .clock     (clock),
        .resetn    (resetn),
        .key_in    (key_r[1]),
        .key_level (key_level_hi),
        .bouncing  (bouncing_hi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic obs, input logic exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reference: the pin reaches the decision logic two clocks late; the output flips
    // once the last D+1 pressed-samples all disagree with the current output.
    logic [1:0]    s1_m;
    logic [1:0]    s2_m;
    logic [1:0]    lvl_m;
    logic [1:0]    bnc_m;
    logic [HW-1:0] hist_m [2];

    function automatic logic next_lvl(input logic [HW-1:0] hist, input logic p, input logic lvl);
        logic [HW-1:0] h;
        h = {hist[HW-2:0], p};
        return (h == {HW{~lvl}}) ? ~lvl : lvl;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_m  <= AL;
            s2_m  <= AL;
            lvl_m <= 2'b00;
            bnc_m <= 2'b00;
            for (int i = 0; i < 2; i++) hist_m[i] <= {HW{1'b0}};
        end else begin
            s1_m <= key_r;
            s2_m <= s1_m;
            for (int i = 0; i < 2; i++) begin
                hist_m[i] <= {hist_m[i][HW-2:0], s2_m[i] ^ AL[i]};
                lvl_m[i]  <= next_lvl(hist_m[i], s2_m[i] ^ AL[i], lvl_m[i]);
                bnc_m[i]  <= (s2_m[i] ^ AL[i]) != next_lvl(hist_m[i], s2_m[i] ^ AL[i], lvl_m[i]);
            end
        end
    end

    always @(negedge clock) begin
        check_val("model_lvl_lo", key_level_lo, lvl_m[0]);
        check_val("model_bnc_lo", bouncing_lo,  bnc_m[0]);
        check_val("model_lvl_hi", key_level_hi, lvl_m[1]);
        check_val("model_bnc_hi", bouncing_hi,  bnc_m[1]);
    end

    initial begin
        int len;
        logic [1:0] seq [6];
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b00;
        seq[3] = 2'b00; seq[4] = 2'b01; seq[5] = 2'b00;

        // Held press through reset, then full qualification after release.
        resetn = 1'b0;
        key_r  = 2'b00;
        repeat (3) begin
            tick();
            check_val("rst_lvl", key_level_lo, 1'b0);
            check_val("rst_bnc", bouncing_lo,  1'b0);
        end
        resetn = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val("t1_lvl", key_level_lo, k == 6);
        end

        // Clean release, then clean press on both polarities, then release again.
        key_r = 2'b01;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val("rel_lvl", key_level_lo, k < 6);
            check_val("rel_bnc", bouncing_lo,  (k >= 2) && (k < 6));
        end
        tick();
        key_r = 2'b10;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val("prs_lvl_lo", key_level_lo, k == 6);
            check_val("prs_bnc_lo", bouncing_lo,  (k >= 2) && (k < 6));
            check_val("prs_lvl_hi", key_level_hi, k == 6);
            check_val("prs_bnc_hi", bouncing_hi,  (k >= 2) && (k < 6));
        end
        key_r = 2'b01;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val("rel2_lvl_hi", key_level_hi, k < 6);
        end
        repeat (2) tick();

        // Three-cycle glitch never reaches the output.
        key_r = 2'b00;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) key_r = 2'b01;
            tick();
            check_val("gl_lvl", key_level_lo, 1'b0);
            check_val("gl_bnc", bouncing_lo,  (k >= 2) && (k <= 4));
        end

        // Bounce train, then held press: output rises 6 edges after the last fall.
        for (int j = 0; j < 5; j++) begin
            key_r = seq[j];
            tick();
        end
        key_r = seq[5];
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val("bt_lvl", key_level_lo, k == 6);
        end
        key_r = 2'b01;
        repeat (8) tick();

        // Reset mid-qualification with key held, then full re-qualification.
        key_r = 2'b00;
        repeat (5) tick();
        check_val("mr_arm", bouncing_lo, 1'b1);
        resetn = 1'b0;
        #1;
        check_val("mr_lvl", key_level_lo, 1'b0);
        check_val("mr_bnc", bouncing_lo,  1'b0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            check_val("mr_req", key_level_lo, k == 6);
        end

        // Random hold lengths with occasional reset pulses, checked by the model.
        for (int n = 0; n < 80; n++) begin
            key_r = 2'($urandom);
            len   = int'($urandom_range(1, 9));
            if ($urandom_range(0, 29) == 0) begin
                resetn = 1'b0;
                tick();
                resetn = 1'b1;
            end
            repeat (len) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
